// File: rtl/trap_seq_pkg.sv
// trap_seq_pkg: shared encodings for the machine-mode trap sequencer.
//   - sequencer state encoding
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - exception / interrupt cause codes and irq_i bit positions
//   - privilege mode encodings
//   - helper deciding whether interrupts are globally enabled
package trap_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_SAVE    = 3'd2,
    ST_RESTORE = 3'd3,
    ST_REDIR   = 3'd4
  } trap_state_e;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Synchronous exception codes
  localparam logic [4:0] EXC_INST_MISALIGN = 5'd0;
  localparam logic [4:0] EXC_ILLEGAL_INST  = 5'd2;
  localparam logic [4:0] EXC_ECALL_U       = 5'd8;
  localparam logic [4:0] EXC_ECALL_M       = 5'd11;

  // Interrupt codes
  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  // Bit positions inside irq_i / mie_i = {meip, mtip, msip}
  localparam int IRQ_BIT_MSI = 0;
  localparam int IRQ_BIT_MTI = 1;
  localparam int IRQ_BIT_MEI = 2;

  // Privilege modes
  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_M = 2'b11;

  // M-mode honours mstatus.MIE; U-mode is always interruptible by M-level sources.
  function automatic logic irq_globally_enabled(input logic [1:0] mode, input logic mie);
    return ((mode == MODE_M) && mie) || (mode == MODE_U);
  endfunction

endpackage

// File: rtl/trap_seq_irq_prio.sv
// trap_irq_prio: masks raw interrupt lines with mie and the global enable,
// then picks one source with priority MEI > MSI > MTI.
// Ports:
//   i_irq         {meip, mtip, msip} raw pending lines
//   i_mie         {MEIE, MTIE, MSIE} per-source enables
//   i_cur_mode    current privilege mode
//   i_mstatus_mie mstatus.MIE
//   o_valid       an enabled interrupt is pending
//   o_cause       its cause code (3, 7 or 11)
module trap_irq_prio
  import trap_seq_pkg::*;
(
  input  logic [2:0] i_irq,
  input  logic [2:0] i_mie,
  input  logic [1:0] i_cur_mode,
  input  logic       i_mstatus_mie,
  output logic       o_valid,
  output logic [4:0] o_cause
);

  logic [2:0] w_enabled;

  assign w_enabled = i_irq & i_mie & {3{irq_globally_enabled(i_cur_mode, i_mstatus_mie)}};

  // Fixed-priority selection; note MSI outranks MTI despite its lower bit index.
  always_comb begin
    o_valid = 1'b0;
    o_cause = 5'd0;
    if (w_enabled[IRQ_BIT_MEI]) begin
      o_valid = 1'b1;
      o_cause = IRQ_MEI;
    end else if (w_enabled[IRQ_BIT_MSI]) begin
      o_valid = 1'b1;
      o_cause = IRQ_MSI;
    end else if (w_enabled[IRQ_BIT_MTI]) begin
      o_valid = 1'b1;
      o_cause = IRQ_MTI;
    end else begin
      o_valid = 1'b0;
      o_cause = 5'd0;
    end
  end

endmodule

// File: rtl/trap_seq.sv
// trap_seq: machine-mode trap entry / MRET exit sequencer.
// Accepts one exception, interrupt or MRET in IDLE, flushes the pipeline,
// writes the trap CSRs (or restores mstatus for MRET) and redirects fetch.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   exc_valid_i/cause/pc/tval     synchronous exception request
//   mret_i                        MRET retired
//   irq_i, mie_i                  interrupt pending lines and enables
//   mstatus_i, mtvec_i, mepc_i    current CSR values
//   cur_mode_i                    current privilege mode
//   irq_pc_i                      PC saved as mepc on interrupts
//   pipe_idle_i, redir_ready_i    pipeline drained / fetch accepts redirect
//   busy_o, flush_o               sequencer active / kill in-flight work
//   csr_we_o, *_wd_o              CSR strobes {mstatus, mtval, mcause, mepc} and data
//   redir_valid_o, redir_pc_o     fetch redirect request and target
module trap_seq
  import trap_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit VEC_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            exc_valid_i,
  input  logic [4:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic [2:0]      irq_i,
  input  logic [2:0]      mie_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [1:0]      cur_mode_i,
  input  logic [XLEN-1:0] irq_pc_i,
  input  logic            pipe_idle_i,
  input  logic            redir_ready_i,
  output logic            busy_o,
  output logic            flush_o,
  output logic [3:0]      csr_we_o,
  output logic [XLEN-1:0] mepc_wd_o,
  output logic [XLEN-1:0] mcause_wd_o,
  output logic [XLEN-1:0] mtval_wd_o,
  output logic [XLEN-1:0] mstatus_wd_o,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o
);

  // Trap entry: stack MIE into MPIE, mask interrupts, record the trapping mode.
  function automatic logic [XLEN-1:0] f_mstatus_enter(input logic [XLEN-1:0] ms,
                                                      input logic [1:0]      mode);
    logic [XLEN-1:0] v;
    v = ms;
    v[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    v[MSTATUS_MIE]  = 1'b0;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mode;
    return v;
  endfunction

  // MRET: pop MPIE back into MIE, set MPIE, drop MPP to the least privileged mode.
  function automatic logic [XLEN-1:0] f_mstatus_mret(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] v;
    v = ms;
    v[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    v[MSTATUS_MPIE] = 1'b1;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MODE_U;
    return v;
  endfunction

  trap_state_e     r_state;
  logic [4:0]      r_cause;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tval;
  logic            r_is_irq;
  logic            r_is_mret;

  logic            r_busy;
  logic            r_flush;
  logic [3:0]      r_csr_we;
  logic [XLEN-1:0] r_mepc_wd;
  logic [XLEN-1:0] r_mcause_wd;
  logic [XLEN-1:0] r_mtval_wd;
  logic [XLEN-1:0] r_mstatus_wd;
  logic            r_redir_valid;
  logic [XLEN-1:0] r_redir_pc;

  logic            w_irq_valid;
  logic [4:0]      w_irq_cause;
  logic [XLEN-1:0] w_vec_offset;
  logic [XLEN-1:0] w_trap_target;
  logic [XLEN-1:0] w_mret_target;
  logic [XLEN-1:0] w_mepc_save;
  logic [XLEN-1:0] w_mcause_save;

  trap_irq_prio u_irq_prio (
    .i_irq         (irq_i),
    .i_mie         (mie_i),
    .i_cur_mode    (cur_mode_i),
    .i_mstatus_mie (mstatus_i[MSTATUS_MIE]),
    .o_valid       (w_irq_valid),
    .o_cause       (w_irq_cause)
  );

  // Vectored mode only applies to interrupts; exceptions always go to the base.
  assign w_vec_offset  = (VEC_EN && (mtvec_i[1:0] == 2'b01) && r_is_irq)
                         ? XLEN'({r_cause, 2'b00}) : {XLEN{1'b0}};
  assign w_trap_target = (mtvec_i & ~XLEN'(2'b11)) + w_vec_offset;
  assign w_mret_target = mepc_i & ~XLEN'(1'b1);
  assign w_mepc_save   = r_pc & ~XLEN'(1'b1);
  assign w_mcause_save = {r_is_irq, {(XLEN-6){1'b0}}, r_cause};

  // Sequencer: arbitration, event capture, state walk and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_cause       <= 5'd0;
      r_pc          <= {XLEN{1'b0}};
      r_tval        <= {XLEN{1'b0}};
      r_is_irq      <= 1'b0;
      r_is_mret     <= 1'b0;
      r_busy        <= 1'b0;
      r_flush       <= 1'b0;
      r_csr_we      <= 4'b0000;
      r_mepc_wd     <= {XLEN{1'b0}};
      r_mcause_wd   <= {XLEN{1'b0}};
      r_mtval_wd    <= {XLEN{1'b0}};
      r_mstatus_wd  <= {XLEN{1'b0}};
      r_redir_valid <= 1'b0;
      r_redir_pc    <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (exc_valid_i) begin
            r_cause   <= exc_cause_i;
            r_pc      <= exc_pc_i;
            r_tval    <= exc_tval_i;
            r_is_irq  <= 1'b0;
            r_is_mret <= 1'b0;
            r_state   <= ST_FLUSH;
            r_busy    <= 1'b1;
            r_flush   <= 1'b1;
          end else if (w_irq_valid) begin
            r_cause   <= w_irq_cause;
            r_pc      <= irq_pc_i;
            r_tval    <= {XLEN{1'b0}};
            r_is_irq  <= 1'b1;
            r_is_mret <= 1'b0;
            r_state   <= ST_FLUSH;
            r_busy    <= 1'b1;
            r_flush   <= 1'b1;
          end else if (mret_i) begin
            r_cause   <= 5'd0;
            r_pc      <= {XLEN{1'b0}};
            r_tval    <= {XLEN{1'b0}};
            r_is_irq  <= 1'b0;
            r_is_mret <= 1'b1;
            r_state   <= ST_FLUSH;
            r_busy    <= 1'b1;
            r_flush   <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // Outputs for SAVE/RESTORE are loaded here so they appear in that state.
          if (pipe_idle_i) begin
            r_flush <= 1'b0;
            if (r_is_mret) begin
              r_state      <= ST_RESTORE;
              r_csr_we     <= 4'b1000;
              r_mstatus_wd <= f_mstatus_mret(mstatus_i);
            end else begin
              r_state      <= ST_SAVE;
              r_csr_we     <= 4'b1111;
              r_mepc_wd    <= w_mepc_save;
              r_mcause_wd  <= w_mcause_save;
              r_mtval_wd   <= r_tval;
              r_mstatus_wd <= f_mstatus_enter(mstatus_i, cur_mode_i);
            end
          end
        end
        ST_SAVE, ST_RESTORE: begin
          // Target is frozen here so later mtvec/mepc changes cannot move it.
          r_state       <= ST_REDIR;
          r_csr_we      <= 4'b0000;
          r_mepc_wd     <= {XLEN{1'b0}};
          r_mcause_wd   <= {XLEN{1'b0}};
          r_mtval_wd    <= {XLEN{1'b0}};
          r_mstatus_wd  <= {XLEN{1'b0}};
          r_redir_valid <= 1'b1;
          r_redir_pc    <= r_is_mret ? w_mret_target : w_trap_target;
        end
        ST_REDIR: begin
          if (redir_ready_i) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= {XLEN{1'b0}};
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_busy        <= 1'b0;
          r_flush       <= 1'b0;
          r_csr_we      <= 4'b0000;
          r_redir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign flush_o       = r_flush;
  assign csr_we_o      = r_csr_we;
  assign mepc_wd_o     = r_mepc_wd;
  assign mcause_wd_o   = r_mcause_wd;
  assign mtval_wd_o    = r_mtval_wd;
  assign mstatus_wd_o  = r_mstatus_wd;
  assign redir_valid_o = r_redir_valid;
  assign redir_pc_o    = r_redir_pc;

endmodule
